// File: rtl/mult_share_arbiter.sv
// Four requesters share one 4x4 unsigned multiplier through a 2-stage pipeline.
// Define MULT_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round robin.

module multiplier_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);
   assign p = {4'd0, a} * {4'd0, b};
endmodule

module mult_share_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req_valid,
   output logic [3:0]  req_ready,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [7:0]  res_p,
   output logic [1:0]  res_id
);
   localparam int NUM_REQ = 4;

   logic [NUM_REQ-1:0][3:0] a_vec, b_vec;
   logic [1:0] run_sync;
   logic       run;
   logic       s1_valid;
   logic [3:0] s1_a, s1_b;
   logic [1:0] s1_id;
   logic [7:0] prod;
   logic       adv1, adv2;
   logic       gnt_hit, xfer;
   logic [1:0] gnt_id;

   assign a_vec = req_a;
   assign b_vec = req_b;

   // Grants wait two edges after reset release so no grant lands on a
   // release edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run_sync <= 2'b00;
      else        run_sync <= {run_sync[0], 1'b1};
   end
   assign run = run_sync[1];

   assign adv2 = !res_valid | res_ready;
   assign adv1 = !s1_valid | adv2;

`ifdef MULT_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt_hit = 1'b0;
      gnt_id  = 2'd0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_valid[k]) begin
            gnt_hit = 1'b1;
            gnt_id  = 2'(k);
         end
      end
   end
`else
   logic [1:0] ptr;
   logic [1:0] idx;

   always_comb begin
      gnt_hit = 1'b0;
      gnt_id  = 2'd0;
      idx     = 2'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ptr + 2'(k);
         if (!gnt_hit && req_valid[idx]) begin
            gnt_hit = 1'b1;
            gnt_id  = idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    ptr <= 2'd0;
      else if (xfer) ptr <= gnt_id + 2'd1;
   end
`endif

   assign req_ready = (run && adv1 && gnt_hit) ? (4'b0001 << gnt_id) : 4'b0000;
   assign xfer      = |req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= 4'd0;
         s1_b     <= 4'd0;
         s1_id    <= 2'd0;
      end else if (adv1) begin
         s1_valid <= xfer;
         if (xfer) begin
            s1_a  <= a_vec[gnt_id];
            s1_b  <= b_vec[gnt_id];
            s1_id <= gnt_id;
         end
      end
   end

   multiplier_4bit u_mult (
      .a (s1_a),
      .b (s1_b),
      .p (prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_p     <= 8'd0;
         res_id    <= 2'd0;
      end else if (adv2) begin
         res_valid <= s1_valid;
         res_p     <= prod;
         res_id    <= s1_id;
      end
   end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter; honours MULT_ARB_FIXED_PRIO_EN.

module tb_mult_share_arbiter;
   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic        res_valid;
   logic        res_ready;
   logic [7:0]  res_p;
   logic [1:0]  res_id;

   int checks = 0;
   int errors = 0;

   mult_share_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_p     (res_p),
      .res_id    (res_id)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = 4'b0;
      res_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic chk_res(string nm, logic v, logic [7:0] p, logic [1:0] id);
      checks++;
      if (res_valid !== v || (v && (res_p !== p || res_id !== id))) begin
         errors++;
         $display("FAIL %s got v=%b p=%0d id=%0d exp v=%b p=%0d id=%0d",
                  nm, res_valid, res_p, res_id, v, p, id);
      end
   endtask

   task automatic chk_rdy(string nm, logic [3:0] exp);
      checks++;
      if (req_ready !== exp) begin
         errors++;
         $display("FAIL %s req_ready got %b exp %b", nm, req_ready, exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      req_valid = 4'hF;
      res_ready = 1'b1;
      req_a = 16'h1234;
      req_b = 16'h5678;
      #2 rst_n = 1'b0;
      #1;
      chk_rdy("reset_async_ready", 4'b0);
      checks++;
      if (res_valid !== 1'b0 || res_p !== 8'd0 || res_id !== 2'd0) begin
         errors++;
         $display("FAIL reset_async_res got v=%b p=%0d id=%0d exp 0 0 0", res_valid, res_p, res_id);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_rdy("reset_held_ready", 4'b0);
      rst_n = 1'b1;
      #1;
      chk_rdy("release_edge_no_grant", 4'b0);
      req_valid = 4'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      do_reset();
      req_a = 16'h0003;
      req_b = 16'h0005;
      req_valid = 4'b0001;
      @(negedge clk);
      chk_rdy("single_grant", 4'b0001);
      chk_res("single_c0", 1'b0, 8'd0, 2'd0);
      @(posedge clk); #1;
      req_valid = 4'b0;
      @(negedge clk);
      chk_rdy("single_ready_once", 4'b0);
      chk_res("single_c1", 1'b0, 8'd0, 2'd0);
      @(negedge clk);
      chk_res("single_result", 1'b1, 8'd15, 2'd0);
      @(negedge clk);
      chk_res("single_no_dup", 1'b0, 8'd0, 2'd0);
   endtask

`ifndef MULT_ARB_FIXED_PRIO_EN
   task automatic test_round_robin();
      logic [7:0] prod [4];
      logic [3:0] exp_rdy;
      do_reset();
      prod = '{8'd18, 8'd12, 8'd42, 8'd225};
      req_a = {4'd15, 4'd6, 4'd4, 4'd2};
      req_b = {4'd15, 4'd7, 4'd3, 4'd9};
      req_valid = 4'hF;
      res_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         exp_rdy = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
         chk_rdy($sformatf("rr_grant_c%0d", c), exp_rdy);
         if (c >= 2) chk_res($sformatf("rr_res_c%0d", c), 1'b1, prod[(c - 2) % 4], 2'((c - 2) % 4));
         if (c == 7) begin
            @(posedge clk); #1;
            req_valid = 4'b0;
         end
      end
   endtask
`endif

   task automatic test_backpressure();
      logic [3:0] exp_rdy [5];
      int nxfer;
      do_reset();
      exp_rdy = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
      nxfer = 0;
      req_a = {4'd0, 4'd13, 4'd5, 4'd0};
      req_b = {4'd0, 4'd11, 4'd5, 4'd0};
      req_valid = 4'b0110;
      res_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk_rdy($sformatf("bp_grant_c%0d", c), exp_rdy[c]);
         if (|req_ready) nxfer++;
         if (c >= 2) chk_res($sformatf("bp_hold_c%0d", c), 1'b1, 8'd25, 2'd1);
         @(posedge clk); #1;
         if (c == 0) req_valid[1] = 1'b0;
         if (c == 1) begin
            req_a[11:8] = 4'd1;
            req_b[11:8] = 4'd1;
         end
      end
      checks++;
      if (nxfer != 2) begin
         errors++;
         $display("FAIL bp_xfer_count got %0d exp 2", nxfer);
      end
      res_ready = 1'b1;
      @(negedge clk);
      chk_rdy("bp_resume_grant", 4'b0100);
      chk_res("bp_out0", 1'b1, 8'd25, 2'd1);
      @(posedge clk); #1;
      req_valid = 4'b0;
      @(negedge clk);
      chk_res("bp_out1", 1'b1, 8'd143, 2'd2);
      @(negedge clk);
      chk_res("bp_out2", 1'b1, 8'd1, 2'd2);
      @(negedge clk);
      chk_res("bp_drain", 1'b0, 8'd0, 2'd0);
   endtask

   task automatic test_reset_mid();
      logic found;
      do_reset();
      found = 1'b0;
      res_ready = 1'b0;
      req_a = {4'd0, 4'd0, 4'd2, 4'd3};
      req_b = {4'd0, 4'd0, 4'd2, 4'd3};
      req_valid = 4'b0011;
      @(negedge clk);
      chk_rdy("mid_fill0", 4'b0001);
      @(negedge clk);
`ifdef MULT_ARB_FIXED_PRIO_EN
      chk_rdy("mid_fill1", 4'b0001);
`else
      chk_rdy("mid_fill1", 4'b0010);
`endif
      @(negedge clk);
      chk_res("mid_full", 1'b1, 8'd9, 2'd0);
      rst_n = 1'b0;
      #1;
      chk_res("mid_reset_clears", 1'b0, 8'd0, 2'd0);
      checks++;
      if (res_p !== 8'd0 || res_id !== 2'd0 || req_ready !== 4'b0) begin
         errors++;
         $display("FAIL mid_reset_regs got p=%0d id=%0d rdy=%b exp 0 0 0000", res_p, res_id, req_ready);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      res_ready = 1'b1;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         chk_res($sformatf("mid_no_stale_c%0d", c), 1'b0, 8'd0, 2'd0);
         if (|req_ready) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL mid_first_grant timeout got none exp 0001");
      end else begin
         chk_rdy("mid_first_grant_idx0", 4'b0001);
         @(posedge clk); #1;
         req_valid = 4'b0;
         @(negedge clk);
         chk_res("mid_lat1", 1'b0, 8'd0, 2'd0);
         @(negedge clk);
         chk_res("mid_after_result", 1'b1, 8'd9, 2'd0);
      end
   endtask

   task automatic test_prio_mode();
      logic [3:0] exp_rdy;
      do_reset();
      req_a = {4'd7, 4'd0, 4'd0, 4'd4};
      req_b = {4'd2, 4'd0, 4'd0, 4'd4};
      req_valid = 4'b1001;
      res_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
`ifdef MULT_ARB_FIXED_PRIO_EN
         exp_rdy = 4'b0001;
`else
         exp_rdy = (c % 2 == 0) ? 4'b0001 : 4'b1000;
`endif
         chk_rdy($sformatf("prio_grant_c%0d", c), exp_rdy);
      end
      req_valid = 4'b0;
   endtask

   initial begin
      test_reset();
      test_single();
`ifndef MULT_ARB_FIXED_PRIO_EN
      test_round_robin();
`endif
      test_backpressure();
      test_reset_mid();
      test_prio_mode();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
